mem_wb: RTL and testbench
=========================

# mem_wb

Pipeline register between the memory-access stage and the register file write port. Captures the MEM-stage result, aligns and extends load data, and presents one registered write (address, data, enable) to the regfile plus an optional HI/LO write. Implements the pipeline stall/bubble/flush rules and counts retired instructions.

## Interface
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_mem  in  1  MEM stage stalled this cycle
- stall_wb  in  1  WB stage stalled this cycle
- flush  in  1  squash pipeline (exception/eret)
- mem_valid  in  1  MEM slot holds a real instruction
- mem_wreg  in  1  instruction writes a GPR
- mem_waddr  in  ADDR_W  destination GPR
- mem_wdata  in  DATA_W  ALU/move result (non-load)
- mem_is_load  in  1  result comes from memory
- mem_load_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5-7 treated as LW
- mem_addr_lo  in  2  byte offset of load address
- mem_rdata  in  DATA_W  raw data-memory word
- mem_whilo  in  1  HI/LO write request (HILO_EN only)
- mem_hi, mem_lo  in  DATA_W  HI/LO values (HILO_EN only)
- wb_valid  out  1  WB slot holds a real instruction
- wb_we  out  1  regfile write enable
- wb_waddr  out  ADDR_W  regfile write address
- wb_wdata  out  DATA_W  regfile write data
- wb_whilo  out  1  HI/LO write enable (HILO_EN only)
- wb_hi, wb_lo  out  DATA_W  HI/LO write data (HILO_EN only)
- retire_cnt  out  32  retired-instruction count

## Operation
- Per-cycle update, evaluated in priority order:
  - rst: all outputs 0.
  - flush: insert bubble.
  - stall_mem=1 and stall_wb=0: insert bubble.
  - stall_mem=1 and stall_wb=1: hold all registers.
  - stall_mem=0: capture.
- Bubble: wb_valid, wb_we, wb_whilo, wb_waddr and wb_wdata all 0; wb_hi and wb_lo 0.
- Capture:
  - wb_valid=mem_valid.
  - wb_we=mem_valid&mem_wreg.
  - wb_whilo=mem_valid&mem_whilo.
  - wb_waddr=mem_waddr. Address 0 is passed through; the regfile ignores it.
  - wb_wdata=mem_wdata when !mem_is_load, else the aligned load value.
- Load alignment is big-endian:
  - Byte select: offset 0 takes rdata[31:24], 1 takes [23:16], 2 takes [15:8], 3 takes [7:0].
  - Halfword select: mem_addr_lo[1]=0 takes [31:16], =1 takes [15:0]; mem_addr_lo[0] is ignored because misalignment is trapped upstream.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the whole word.
- retire_cnt:
  - Increments by 1 on each capture with mem_valid=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Unchanged on bubble, hold or flush; cleared only by rst.

## Timing
- Latency is 1 cycle: MEM inputs sampled at edge N appear on wb_* after edge N, and the regfile writes them at edge N+1.
- All outputs are registered; there is no combinational input-to-output path.
- During a hold, outputs stay stable for any number of cycles.
- flush together with a stall gives a bubble.
- rst mid-stall clears everything, including held state.
- A capture after a bubble needs no dead cycle.

## Configuration
- Macro: MEM_WB_HILO_EN.
- Defined: the mem_whilo, mem_hi, mem_lo, wb_whilo, wb_hi and wb_lo ports and their registers exist. They follow the same capture, bubble, hold and reset rules as wb_we and wb_wdata.
- Undefined: those ports and registers are absent, and the block carries only the GPR path.

## Structure
- Shared package holds:
  - ZeroWord, the RegAddrBus/RegBus widths, and the load-op encodings LB_OP to LW_OP.
  - The enable polarity constants WriteEnable and ReadEnable.
- Optional sub-module load_align: a purely combinational extractor/extender (rdata, addr_lo, load_op → word).
- The capture, stall and retire-counter logic stays in mem_wb.

## Test plan
- Reset: rst=1 for 2 cycles → all outputs 0 and retire_cnt=0. After release, with stall_mem=0, mem_valid=1, mem_wreg=1, mem_waddr=3, mem_wdata=0x12345678, one edge later → wb_we=1, wb_waddr=3, wb_wdata=0x12345678, retire_cnt=1.
- Loads, mem_rdata=0x80FF7F01, mem_is_load=1:
  - LB with offset 0 → 0xFFFFFF80.
  - LBU with offset 1 → 0x000000FF.
  - LH with offset 2 → 0x00007F01.
  - LHU with offset 0 → 0x000080FF.
  - LW → 0x80FF7F01.
- Stalls with a valid instruction captured:
  - stall_mem=1, stall_wb=1 for 3 cycles → outputs unchanged and retire_cnt unchanged.
  - Then stall_wb=0 → bubble: wb_we=0, wb_valid=0.
- Flush: flush=1 with stall_mem=0, mem_valid=1 → next cycle wb_we=0, wb_valid=0, retire_cnt unchanged.
- Counter wrap: force retire_cnt to 0xFFFFFFFF, then capture one valid instruction → retire_cnt=0.
- HI/LO (MEM_WB_HILO_EN): mem_whilo=1, mem_hi=0xA, mem_lo=0xB → wb_whilo=1, wb_hi=0xA, wb_lo=0xB. A following bubble → wb_whilo=0.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared definitions for the MEM/WB pipeline register.
//   RegBus / RegAddrBus : datapath and register-address widths
//   ZeroWord            : all-zero datapath word
//   WriteEnable/Disable : regfile write-enable polarity
//   ReadEnable/Disable  : memory-read (load result) polarity
//   load_op_e           : load-op encodings LB_OP .. LW_OP (5-7 behave as LW)
//   sext8/sext16/zext8/zext16 : extension helpers used by load alignment
package mem_wb_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    typedef enum logic [2:0] {
        LB_OP  = 3'd0,
        LBU_OP = 3'd1,
        LH_OP  = 3'd2,
        LHU_OP = 3'd3,
        LW_OP  = 3'd4
    } load_op_e;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] zext8(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] h);
        return {16'h0000, h};
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// mem_wb_if: MEM-stage result bundle into the MEM/WB register and the
// registered write-back bundle out of it.
//   master modport : drives mem_* and stall/flush, observes wb_* and retire_cnt
//   slave modport  : the mem_wb register itself
// Optional macro MEM_WB_HILO_EN adds mem_whilo/mem_hi/mem_lo and
// wb_whilo/wb_hi/wb_lo.
import mem_wb_pkg::*;

interface mem_wb_if #(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
);
    logic              stall_mem;
    logic              stall_wb;
    logic              flush;
    logic              mem_valid;
    logic              mem_wreg;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_is_load;
    logic [2:0]        mem_load_op;
    logic [1:0]        mem_addr_lo;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic [31:0]       retire_cnt;
`ifdef MEM_WB_HILO_EN
    logic              mem_whilo;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
`endif

    modport master (
        output stall_mem, stall_wb, flush,
        output mem_valid, mem_wreg, mem_waddr, mem_wdata,
        output mem_is_load, mem_load_op, mem_addr_lo, mem_rdata,
`ifdef MEM_WB_HILO_EN
        output mem_whilo, mem_hi, mem_lo,
        input  wb_whilo, wb_hi, wb_lo,
`endif
        input  wb_valid, wb_we, wb_waddr, wb_wdata, retire_cnt
    );

    modport slave (
        input  stall_mem, stall_wb, flush,
        input  mem_valid, mem_wreg, mem_waddr, mem_wdata,
        input  mem_is_load, mem_load_op, mem_addr_lo, mem_rdata,
`ifdef MEM_WB_HILO_EN
        input  mem_whilo, mem_hi, mem_lo,
        output wb_whilo, wb_hi, wb_lo,
`endif
        output wb_valid, wb_we, wb_waddr, wb_wdata, retire_cnt
    );

endinterface

// File: rtl/mem_wb_load_align.sv
// mem_wb_load_align: purely combinational big-endian load extractor.
//   rdata   in  32 raw data-memory word
//   addr_lo in  2  byte offset (bit 0 ignored for halfwords; misalignment
//                  is trapped upstream)
//   load_op in  3  LB/LBU/LH/LHU/LW; codes 5-7 behave as LW
//   word    out 32 aligned, extended load value
import mem_wb_pkg::*;

module mem_wb_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_op,
    output logic [31:0] word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Big-endian lane select: offset 0 is the most significant byte.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = rdata[31:24];
            2'd1:    byte_s = rdata[23:16];
            2'd2:    byte_s = rdata[15:8];
            2'd3:    byte_s = rdata[7:0];
            default: byte_s = rdata[31:24];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[15:0];
        end else begin
            half_s = rdata[31:16];
        end
    end

    // Extension by load kind; unknown codes fall back to a full word.
    always_comb begin
        word = rdata;
        case (load_op_e'(load_op))
            LB_OP:   word = sext8(byte_s);
            LBU_OP:  word = zext8(byte_s);
            LH_OP:   word = sext16(half_s);
            LHU_OP:  word = zext16(half_s);
            LW_OP:   word = rdata;
            default: word = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_wb_if.slave -- stall/flush controls, MEM-stage result in,
//              registered regfile write (wb_valid/wb_we/wb_waddr/wb_wdata)
//              and retire_cnt out
// Per edge, highest priority first: rst clears, flush bubbles, a MEM stall
// with WB free bubbles, a stall of both holds, otherwise capture.
// Optional macro MEM_WB_HILO_EN adds the registered HI/LO write path.
import mem_wb_pkg::*;

module mem_wb #(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input logic     clk,
    input logic     rst,
    mem_wb_if.slave bus
);

    logic              valid_r;
    logic              we_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [31:0]       cnt_r;

    logic [DATA_W-1:0] load_word_s;
    logic [DATA_W-1:0] wdata_s;
    logic              we_s;
    logic              bubble_s;
    logic              hold_s;

    mem_wb_load_align u_align (
        .rdata   (bus.mem_rdata),
        .addr_lo (bus.mem_addr_lo),
        .load_op (bus.mem_load_op),
        .word    (load_word_s)
    );

    // Next-capture values and the stall/flush decode.
    always_comb begin
        wdata_s  = bus.mem_wdata;
        we_s     = WriteDisable;
        bubble_s = 1'b0;
        hold_s   = 1'b0;
        if (bus.mem_is_load == ReadEnable) begin
            wdata_s = load_word_s;
        end else begin
            wdata_s = bus.mem_wdata;
        end
        if (bus.mem_valid && bus.mem_wreg) begin
            we_s = WriteEnable;
        end else begin
            we_s = WriteDisable;
        end
        // Flush outranks any stall, so flush plus hold still bubbles.
        if (bus.flush) begin
            bubble_s = 1'b1;
        end else if (bus.stall_mem) begin
            bubble_s = !bus.stall_wb;
            hold_s   = bus.stall_wb;
        end else begin
            bubble_s = 1'b0;
            hold_s   = 1'b0;
        end
    end

    // GPR write-back registers and the retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            we_r    <= WriteDisable;
            waddr_r <= '0;
            wdata_r <= ZeroWord;
            cnt_r   <= 32'd0;
        end else if (bubble_s) begin
            valid_r <= 1'b0;
            we_r    <= WriteDisable;
            waddr_r <= '0;
            wdata_r <= ZeroWord;
        end else if (hold_s) begin
            valid_r <= valid_r;
        end else begin
            valid_r <= bus.mem_valid;
            we_r    <= we_s;
            waddr_r <= bus.mem_waddr;
            wdata_r <= wdata_s;
            // Natural 32-bit wrap from all-ones back to zero.
            if (bus.mem_valid) begin
                cnt_r <= cnt_r + 32'd1;
            end
        end
    end

    assign bus.wb_valid   = valid_r;
    assign bus.wb_we      = we_r;
    assign bus.wb_waddr   = waddr_r;
    assign bus.wb_wdata   = wdata_r;
    assign bus.retire_cnt = cnt_r;

`ifdef MEM_WB_HILO_EN
    logic              whilo_r;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;

    // HI/LO write registers follow the same rules as the GPR write.
    always_ff @(posedge clk) begin
        if (rst) begin
            whilo_r <= WriteDisable;
            hi_r    <= ZeroWord;
            lo_r    <= ZeroWord;
        end else if (bubble_s) begin
            whilo_r <= WriteDisable;
            hi_r    <= ZeroWord;
            lo_r    <= ZeroWord;
        end else if (hold_s) begin
            whilo_r <= whilo_r;
        end else begin
            whilo_r <= bus.mem_valid & bus.mem_whilo;
            hi_r    <= bus.mem_hi;
            lo_r    <= bus.mem_lo;
        end
    end

    assign bus.wb_whilo = whilo_r;
    assign bus.wb_hi    = hi_r;
    assign bus.wb_lo    = lo_r;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed and randomized bench for mem_wb with a behavioural
// reference model of the pipeline-register rules.
module tb_mem_wb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mem_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic        m_valid, m_we, m_whilo;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_hi, m_lo, m_cnt;

    function automatic logic [31:0] ref_load(input logic [31:0] rd,
                                             input logic [1:0] off,
                                             input logic [2:0] op);
        int unsigned b;
        int unsigned h;
        b = (rd >> (8 * (3 - int'(off)))) & 32'hFF;
        h = off[1] ? (rd & 32'hFFFF) : (rd >> 16);
        case (op)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return b;
            3'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd3:    return h;
            default: return rd;
        endcase
    endfunction

    // One clock edge of the reference model using the inputs in force now.
    task automatic model_edge();
        logic do_bubble;
        logic do_hold;
        do_bubble = bus.flush || (bus.stall_mem && !bus.stall_wb);
        do_hold   = !bus.flush && bus.stall_mem && bus.stall_wb;
        if (rst) begin
            {m_valid, m_we, m_whilo} = 3'b000;
            m_waddr = 5'd0; m_wdata = 32'd0; m_hi = 32'd0; m_lo = 32'd0; m_cnt = 32'd0;
        end else if (do_bubble) begin
            {m_valid, m_we, m_whilo} = 3'b000;
            m_waddr = 5'd0; m_wdata = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
        end else if (!do_hold) begin
            m_valid = bus.mem_valid;
            m_we    = bus.mem_valid && bus.mem_wreg;
            m_waddr = bus.mem_waddr;
            m_wdata = bus.mem_is_load ? ref_load(bus.mem_rdata, bus.mem_addr_lo, bus.mem_load_op)
                                      : bus.mem_wdata;
`ifdef MEM_WB_HILO_EN
            m_whilo = bus.mem_valid && bus.mem_whilo;
            m_hi    = bus.mem_hi;
            m_lo    = bus.mem_lo;
`endif
            m_cnt   = m_cnt + (bus.mem_valid ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, {31'd0, bus.wb_valid}, {31'd0, m_valid});
        check({tag, ".we"},    {31'd0, bus.wb_we},    {31'd0, m_we});
        check({tag, ".waddr"}, {27'd0, bus.wb_waddr}, {27'd0, m_waddr});
        check({tag, ".wdata"}, bus.wb_wdata, m_wdata);
        check({tag, ".cnt"},   bus.retire_cnt, m_cnt);
`ifdef MEM_WB_HILO_EN
        check({tag, ".whilo"}, {31'd0, bus.wb_whilo}, {31'd0, m_whilo});
        check({tag, ".hi"},    bus.wb_hi, m_hi);
        check({tag, ".lo"},    bus.wb_lo, m_lo);
`endif
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.stall_mem = 1'b0; bus.stall_wb = 1'b0; bus.flush = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_wreg = 1'b0; bus.mem_waddr = 5'd0;
        bus.mem_wdata = 32'd0; bus.mem_is_load = 1'b0; bus.mem_load_op = 3'd0;
        bus.mem_addr_lo = 2'd0; bus.mem_rdata = 32'd0;
`ifdef MEM_WB_HILO_EN
        bus.mem_whilo = 1'b0; bus.mem_hi = 32'd0; bus.mem_lo = 32'd0;
`endif
    endtask

    task automatic random_payload();
        bus.mem_valid   = 1'($urandom_range(0, 3) != 0);
        bus.mem_wreg    = 1'($urandom_range(0, 1));
        bus.mem_waddr   = 5'($urandom);
        bus.mem_wdata   = $urandom;
        bus.mem_is_load = 1'($urandom_range(0, 1));
        bus.mem_load_op = 3'($urandom);
        bus.mem_addr_lo = 2'($urandom);
        bus.mem_rdata   = $urandom;
`ifdef MEM_WB_HILO_EN
        bus.mem_whilo   = 1'($urandom_range(0, 1));
        bus.mem_hi      = $urandom;
        bus.mem_lo      = $urandom;
`endif
    endtask

    logic [2:0]  ld_op  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [1:0]  ld_off [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01,
                                32'h0000_80FF, 32'h80FF_7F01};

    initial begin
        logic [31:0] held_data;
        logic [31:0] held_cnt;

        idle_inputs();
        rst = 1'b1;
        m_cnt = 32'hDEAD_BEEF;
        model_edge();

        // reset for two cycles
        cycle("rst0");
        cycle("rst1");
        check("rst.cnt_zero", bus.retire_cnt, 32'd0);
        check("rst.we_zero", {31'd0, bus.wb_we}, 32'd0);

        // first capture
        rst = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_wreg = 1'b1;
        bus.mem_waddr = 5'd3; bus.mem_wdata = 32'h1234_5678;
        cycle("cap1");
        check("cap1.wdata_k", bus.wb_wdata, 32'h1234_5678);
        check("cap1.cnt_k", bus.retire_cnt, 32'd1);

        // big-endian load alignment table
        bus.mem_is_load = 1'b1; bus.mem_rdata = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            bus.mem_load_op = ld_op[i];
            bus.mem_addr_lo = ld_off[i];
            cycle("load");
            check("load.k", bus.wb_wdata, ld_exp[i]);
        end

        // hold for three cycles with a valid instruction captured
        held_data = bus.wb_wdata;
        held_cnt  = bus.retire_cnt;
        bus.stall_mem = 1'b1; bus.stall_wb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            random_payload();
            cycle("hold");
            check("hold.data_k", bus.wb_wdata, held_data);
            check("hold.cnt_k", bus.retire_cnt, held_cnt);
        end

        // release WB only -> bubble
        bus.stall_wb = 1'b0;
        cycle("bubble");
        check("bubble.valid_k", {31'd0, bus.wb_valid}, 32'd0);

        // capture straight after the bubble
        idle_inputs();
        bus.mem_valid = 1'b1; bus.mem_wreg = 1'b1; bus.mem_waddr = 5'd7;
        bus.mem_wdata = 32'hCAFE_0001;
        cycle("after_bubble");

        // flush with a valid instruction offered
        held_cnt = bus.retire_cnt;
        bus.flush = 1'b1;
        cycle("flush");
        check("flush.cnt_k", bus.retire_cnt, held_cnt);
        check("flush.we_k", {31'd0, bus.wb_we}, 32'd0);

        // flush together with a full stall still bubbles
        bus.flush = 1'b0;
        cycle("pre_fs");
        bus.flush = 1'b1; bus.stall_mem = 1'b1; bus.stall_wb = 1'b1;
        cycle("flush_stall");
        idle_inputs();

        // counter wrap
        force dut.cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_r;
        m_cnt = 32'hFFFF_FFFF;
        bus.mem_valid = 1'b1; bus.mem_wreg = 1'b1; bus.mem_waddr = 5'd1;
        cycle("wrap");
        check("wrap.cnt_k", bus.retire_cnt, 32'd0);

`ifdef MEM_WB_HILO_EN
        bus.mem_whilo = 1'b1; bus.mem_hi = 32'hA; bus.mem_lo = 32'hB;
        cycle("hilo");
        check("hilo.hi_k", bus.wb_hi, 32'hA);
        check("hilo.whilo_k", {31'd0, bus.wb_whilo}, 32'd1);
        bus.stall_mem = 1'b1;
        cycle("hilo_bubble");
        check("hilo_bubble.whilo_k", {31'd0, bus.wb_whilo}, 32'd0);
        idle_inputs();
`endif

        // reset during a hold clears held state
        bus.mem_valid = 1'b1; bus.mem_wreg = 1'b1; bus.mem_wdata = 32'h5555_AAAA;
        cycle("pre_rst");
        bus.stall_mem = 1'b1; bus.stall_wb = 1'b1;
        cycle("pre_rst_hold");
        rst = 1'b1;
        cycle("rst_in_hold");
        check("rst_in_hold.cnt_k", bus.retire_cnt, 32'd0);
        rst = 1'b0;
        idle_inputs();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            random_payload();
            bus.flush     = 1'($urandom_range(0, 9) == 0);
            bus.stall_mem = 1'($urandom_range(0, 3) == 0);
            bus.stall_wb  = 1'($urandom_range(0, 1));
            rst           = 1'($urandom_range(0, 59) == 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
